// File: rtl/add_pkg.sv
// Shared definitions for the stride operand source: FSM state encoding and
// default data/count widths used by the source and its add_one consumer.
package add_pkg;

    localparam int DEF_WIDTH     = 9;
    localparam int DEF_CNT_WIDTH = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : add_pkg

// File: rtl/add_one.sv
// Downstream stage fed by add_stride_source: presents its operand plus one,
// wrapping modulo 2^WIDTH.
module add_one
    import add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = a + WIDTH'(1);

endmodule : add_one

// File: rtl/add_stride_source.sv
// Operand source: emits base, base+stride, ... (count operands) on a
// valid/ready interface, with abort, single-cycle done and async reset.
module add_stride_source
    import add_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [WIDTH-1:0]     stride,
    input  logic [CNT_WIDTH-1:0] count,
    input  logic                 abort,
    output logic [WIDTH-1:0]     x,
    output logic                 x_valid,
    input  logic                 x_ready,
    output logic                 busy,
    output logic                 done
);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      x_q, x_d;
    logic [WIDTH-1:0]      stride_q, stride_d;
    logic [CNT_WIDTH-1:0]  rem_q, rem_d;
    logic                  valid_q, valid_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            stride_q <= '0;
            rem_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            stride_q <= stride_d;
            rem_q    <= rem_d;
            valid_q  <= valid_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        stride_d = stride_q;
        rem_d    = rem_q;
        valid_d  = valid_q;

        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    if (count != '0) begin
                        x_d      = base;
                        stride_d = stride;
                        rem_d    = count;
                        valid_d  = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                if (valid_q && x_ready) begin
                    x_d   = x_q + stride_q;
                    rem_d = rem_q - CNT_WIDTH'(1);
                    if (rem_q == CNT_WIDTH'(1)) begin
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end
                // Abort wins over completion; a coincident transfer still counts.
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // All outputs decode registers only, so x_ready/abort never reach x/x_valid.
    assign x       = x_q;
    assign x_valid = valid_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule : add_stride_source
